// File: rtl/core_ctrl_pkg.sv
// Shared control definitions for the multicycle core: micro-PC state encodings and opcodes.
// Pure declarations; no logic, no latency.
// Used by the sequencer, the control ROM and the bench.
package core_ctrl_pkg;

  // Micro-PC encodings; values 10..31 are never produced by the sequencer.
  typedef enum logic [4:0] {
    FETCH    = 5'd0,
    DECODE   = 5'd1,
    MEMADR   = 5'd2,
    MEMREAD  = 5'd3,
    MEMWB    = 5'd4,
    MEMWRITE = 5'd5,
    EXECR    = 5'd6,
    EXECI    = 5'd7,
    ALUWB    = 5'd8,
    BRANCH   = 5'd9
  } upc_t;

  // Supported major opcodes (instruction bits [6:0]).
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: registered micro-PC, opcode dispatch, retire counting, sticky error flags.
// upc advances one state per clock; retire is a registered pulse one cycle after completion.
// Memory states stall (hold=1) until mem_ready, or fall back to FETCH after TIMEOUT waiting cycles.
module micro_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             clr_flags,
  output logic [4:0]       upc,
  output logic             hold,
  output logic             branch_taken,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             illegal_flag,
  output logic             bus_err
);

  // Wait counter only ever needs to reach TIMEOUT-1.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic TIMEOUT_EN = (TIMEOUT > 0);

  upc_t              upc_q, upc_d;
  logic              is_store_q, is_store_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              retire_q, retire_d;
  logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;
  logic              illegal_set;
  logic              timeout;

  // State and bookkeeping registers; reset acts immediately, even mid-instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upc_q       <= FETCH;
      is_store_q  <= 1'b0;
      wait_q      <= '0;
      retire_q    <= 1'b0;
      instr_cnt_q <= '0;
      illegal_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      upc_q       <= upc_d;
      is_store_q  <= is_store_d;
      wait_q      <= wait_d;
      retire_q    <= retire_d;
      instr_cnt_q <= instr_cnt_d;
      illegal_q   <= illegal_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Next-state: timeout overrides the normal transition; mem_ready clears hold so it wins over timeout.
  always_comb begin
    upc_d       = upc_q;
    retire_d    = 1'b0;
    illegal_set = 1'b0;
    timeout     = TIMEOUT_EN && hold && (wait_q == WAIT_LAST);
    if (timeout) begin
      upc_d = FETCH;
    end else begin
      case (upc_q)
        FETCH:    if (mem_ready) upc_d = DECODE;
        DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: upc_d = MEMADR;
            OP_R:              upc_d = EXECR;
            OP_I:              upc_d = EXECI;
            OP_BRANCH:         upc_d = BRANCH;
            default: begin
              upc_d       = FETCH;
              illegal_set = 1'b1;
              retire_d    = 1'b1;
            end
          endcase
        end
        MEMADR:   upc_d = is_store_q ? MEMWRITE : MEMREAD;
        MEMREAD:  if (mem_ready) upc_d = MEMWB;
        MEMWB: begin
          upc_d    = FETCH;
          retire_d = 1'b1;
        end
        MEMWRITE: begin
          if (mem_ready) begin
            upc_d    = FETCH;
            retire_d = 1'b1;
          end
        end
        EXECR, EXECI: upc_d = ALUWB;
        ALUWB, BRANCH: begin
          upc_d    = FETCH;
          retire_d = 1'b1;
        end
        default:  upc_d = FETCH;
      endcase
    end
  end

  // Outputs decoded from the current micro-PC.
  always_comb begin
    hold         = (upc_q == FETCH || upc_q == MEMREAD || upc_q == MEMWRITE) && !mem_ready;
    branch_taken = (upc_q == BRANCH) && zero;
  end

  // Side state: store latch, wait counter, retire count and sticky flags (set beats clear).
  always_comb begin
    is_store_d  = (upc_q == DECODE) ? (op == OP_STORE) : is_store_q;
    wait_d      = (hold && !timeout) ? wait_q + 1'b1 : '0;
    instr_cnt_d = instr_cnt_q + CNT_W'(retire_d);
    illegal_d   = illegal_set | (illegal_q & ~clr_flags);
    bus_err_d   = timeout | (bus_err_q & ~clr_flags);
  end

  assign upc          = upc_q;
  assign retire       = retire_q;
  assign instr_cnt    = instr_cnt_q;
  assign illegal_flag = illegal_q;
  assign bus_err      = bus_err_q;

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram sequencer for the multicycle core. It holds the micro-PC that addresses the 17-bit control ROM, dispatches on the instruction opcode in DECODE, and stretches memory states until the memory handshakes.
- Also generates the branch-taken strobe, the instruction retire pulse and count, and sticky illegal-opcode and bus-timeout flags.
- Sits between the datapath status signals (op, zero, mem_ready) and the control ROM address input.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- TIMEOUT, 16: maximum number of cycles a memory state waits for mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  7  opcode field from the instruction register; valid in DECODE.
- zero  in  1  ALU zero flag; valid in BRANCH.
- mem_ready  in  1  memory has completed the current access this cycle.
- clr_flags  in  1  synchronous clear of illegal_flag and bus_err.
- upc  out  5  micro-PC, driven to the ROM address; registered.
- hold  out  1  current memory state is waiting; the datapath ANDs every ROM write enable with ~hold.
- branch_taken  out  1  combinational; equals (upc==BRANCH) & zero.
- retire  out  1  registered one-cycle pulse when an instruction completes.
- instr_cnt  out  CNT_W  count of retired instructions; wraps modulo 2^CNT_W.
- illegal_flag  out  1  sticky; set when DECODE sees an unsupported opcode.
- bus_err  out  1  sticky; set on a memory wait timeout.

Behaviour:
- States and upc encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECR=6, EXECI=7, ALUWB=8, BRANCH=9
  - Encodings 10–31 are never produced; if reached (e.g. SEU), the next state is FETCH.
- Reset (asynchronous, takes effect immediately, including mid-instruction): upc=FETCH, retire=0, instr_cnt=0, illegal_flag=0, bus_err=0, wait counter=0.
- Memory states are FETCH, MEMREAD and MEMWRITE. hold = memory state & ~mem_ready. While hold=1, upc stays put and the wait counter increments.
- Transitions:
  - FETCH -> DECODE on mem_ready.
  - DECODE dispatches on op:
    - 0000011 -> MEMADR
    - 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - any other value -> FETCH, set illegal_flag, pulse retire.
  - MEMADR -> MEMREAD if the op captured in DECODE was a load; -> MEMWRITE if it was a store. The sequencer latches an is_store bit in DECODE, so a change on op after DECODE is ignored.
  - MEMREAD -> MEMWB on mem_ready.
  - MEMWB -> FETCH.
  - MEMWRITE -> FETCH on mem_ready.
  - EXECR and EXECI -> ALUWB.
  - ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Retire: pulses in the cycle after the machine leaves MEMWB, MEMWRITE (on mem_ready), ALUWB, BRANCH, or DECODE with an illegal opcode. instr_cnt increments on the same edge that sets retire.
- Timeout (TIMEOUT>0): when the wait counter reaches TIMEOUT-1 while hold=1, the next state is FETCH.
  - bus_err is set.
  - No retire pulse, and instr_cnt is unchanged.
  - The wait counter resets on every state change.
  - If mem_ready arrives in the same cycle as the timeout, mem_ready wins: normal transition, no error.
- Flag clearing: clr_flags clears both sticky flags on the next edge. If a set event occurs in the same cycle as clr_flags, the flag ends set (set has priority).
- Counter wrap: instr_cnt wraps from all-ones to 0 without any flag.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - upc_t, a 5-bit enum of the ten state encodings (reused by the ROM and the bench);
  - the opcode constants OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH.
- No sub-module is needed; the wait/timeout counter stays inline.

Test Plan:
- Reset and load: hold reset_n=0, then release; op=0000011 in DECODE, mem_ready always 1 -> upc sequence 0,1,2,3,4,0; retire high once; instr_cnt=1.
- Store with wait: op=0100011, mem_ready low for 3 cycles in MEMWRITE -> upc=5 for 4 cycles, hold=1 for 3 of them, then FETCH and retire.
- Branch: op=1100011 with zero=1 -> branch_taken=1 only while upc=9; repeat with zero=0 -> branch_taken never asserts.
- Illegal opcode: op=1111111 -> DECODE goes to FETCH; illegal_flag=1 and stays set; a clr_flags pulse clears it; instr_cnt increments.
- Timeout: TIMEOUT=4, mem_ready=0 in FETCH -> bus_err=1 after 4 cycles, upc re-enters FETCH, instr_cnt unchanged; repeat with mem_ready=1 on cycle 4 -> no bus_err.
- Reset mid-instruction and counter wrap: assert reset_n=0 while upc=3 -> upc=0 without waiting for a clock edge. With CNT_W=4, 16 retires -> instr_cnt wraps to 0.
